// File: rtl/dmem_arbiter_32.sv
// Shares the single-port data memory between the CPU port (0) and the loader/debug port (1).
// Latency: request sampled in IDLE -> ack two edges later; one transaction per three cycles.
// Backpressure: requesters hold req until their one-cycle ack; DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module dmem_arbiter_32 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read_enabled,
  output logic                  mem_write_enabled,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  logic                  gnt;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  any_req;
  logic                  sel1;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  // On a tie the port that did not win last time goes first.
  assign sel1 = p1_req & (~p0_req | ~last_gnt);

  always_ff @(posedge clock) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (state == IDLE && any_req)
      last_gnt <= sel1;
  end
`else
  assign sel1 = p1_req & ~p0_req;
`endif

  assign win_we    = sel1 ? p1_we    : p0_we;
  assign win_addr  = sel1 ? p1_addr  : p0_addr;
  assign win_wdata = sel1 ? p1_wdata : p0_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      gnt               <= 1'b0;
      we_q              <= 1'b0;
      err_q             <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      p0_ack            <= 1'b0;
      p1_ack            <= 1'b0;
      mem_read_enabled  <= 1'b0;
      mem_write_enabled <= 1'b0;
    end else begin
      p0_ack            <= 1'b0;
      p1_ack            <= 1'b0;
      mem_read_enabled  <= 1'b0;
      mem_write_enabled <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt               <= sel1;
            we_q              <= win_we;
            addr_q            <= win_addr;
            wdata_q           <= win_wdata;
            // Enables are registered so they are high exactly during ACCESS.
            mem_write_enabled <= win_we;
            mem_read_enabled  <= ~win_we;
            state             <= ACCESS;
          end
        end
        ACCESS: begin
          err_q  <= mem_err;
          p0_ack <= ~gnt;
          p1_ack <= gnt;
          state  <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  // Memory read data is registered, so it is valid during RESP and passed straight through.
  assign p0_rdata = (p0_ack && !we_q) ? mem_rdata : '0;
  assign p1_rdata = (p1_ack && !we_q) ? mem_rdata : '0;
  assign p0_err   = p0_ack & err_q;
  assign p1_err   = p1_ack & err_q;

endmodule
